// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register and operand-issue stage feeding the ALU.
// Optional feature macro: EX_FWD_EN (mem/wb operand bypass; undefined = stall until the register refresh lands).
module ex_issue_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [WIDTH-1:0]    id_pc,
  input  logic [WIDTH-1:0]    id_rs1_val,
  input  logic [WIDTH-1:0]    id_rs2_val,
  input  logic [WIDTH-1:0]    id_imm,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_asel,
  input  logic                id_bsel,
  input  logic [3:0]          id_alu_ctrl,
  input  logic                flush,
  input  logic                mem_wen,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic                mem_is_load,
  input  logic [WIDTH-1:0]    mem_result,
  input  logic                wb_wen,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic [WIDTH-1:0]    wb_result,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [3:0]          alu_control,
  output logic [REG_BITS-1:0] ex_rd
);

  typedef struct packed {
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    rs1_val;
    logic [WIDTH-1:0]    rs2_val;
    logic [WIDTH-1:0]    imm;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                asel;
    logic                bsel;
    logic [3:0]          ctrl;
  } entry_t;

  entry_t entry_q, entry_d;
  logic   held_valid_q, held_valid_d;
  // lock_q: the op was presented but not consumed; operands are frozen until it leaves.
  logic   lock_q, lock_d;

  logic use_rs1, use_rs2;
  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic hazard, transfer, consume;
  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;

  assign use_rs1  = !entry_q.asel;
  assign use_rs2  = !entry_q.bsel;
  assign mem_hit1 = mem_wen && (mem_rd == entry_q.rs1) && (entry_q.rs1 != '0);
  assign mem_hit2 = mem_wen && (mem_rd == entry_q.rs2) && (entry_q.rs2 != '0);
  assign wb_hit1  = wb_wen  && (wb_rd  == entry_q.rs1) && (entry_q.rs1 != '0);
  assign wb_hit2  = wb_wen  && (wb_rd  == entry_q.rs2) && (entry_q.rs2 != '0);

`ifdef EX_FWD_EN
  assign hazard  = held_valid_q && !lock_q && mem_is_load &&
                   ((use_rs1 && mem_hit1) || (use_rs2 && mem_hit2));
  assign rs1_fwd = lock_q ? entry_q.rs1_val :
                   (mem_hit1 && !mem_is_load) ? mem_result :
                   wb_hit1 ? wb_result : entry_q.rs1_val;
  assign rs2_fwd = lock_q ? entry_q.rs2_val :
                   (mem_hit2 && !mem_is_load) ? mem_result :
                   wb_hit2 ? wb_result : entry_q.rs2_val;
`else
  assign hazard  = held_valid_q && !lock_q &&
                   ((use_rs1 && (mem_hit1 || wb_hit1)) || (use_rs2 && (mem_hit2 || wb_hit2)));
  assign rs1_fwd = entry_q.rs1_val;
  assign rs2_fwd = entry_q.rs2_val;
`endif

  assign ex_valid    = held_valid_q && !hazard;
  assign id_ready    = !held_valid_q || (ex_valid && ex_ready);
  assign transfer    = id_valid && id_ready;
  assign consume     = ex_valid && ex_ready;
  assign alu_a       = entry_q.asel ? entry_q.pc  : rs1_fwd;
  assign alu_b       = entry_q.bsel ? entry_q.imm : rs2_fwd;
  assign alu_control = entry_q.ctrl;
  assign ex_rd       = entry_q.rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    entry_d      = entry_q;
    held_valid_d = held_valid_q;
    lock_d       = lock_q;
    if (flush) begin
      held_valid_d = 1'b0;
      lock_d       = 1'b0;
    end else if (transfer) begin
      held_valid_d    = 1'b1;
      lock_d          = 1'b0;
      entry_d.pc      = id_pc;
      entry_d.imm     = id_imm;
      entry_d.rs1     = id_rs1;
      entry_d.rs2     = id_rs2;
      entry_d.rd      = id_rd;
      entry_d.asel    = id_asel;
      entry_d.bsel    = id_bsel;
      entry_d.ctrl    = id_alu_ctrl;
      // A writeback landing on this edge is not yet visible in the ID read values.
      entry_d.rs1_val = (wb_wen && wb_rd == id_rs1 && id_rs1 != '0) ? wb_result : id_rs1_val;
      entry_d.rs2_val = (wb_wen && wb_rd == id_rs2 && id_rs2 != '0) ? wb_result : id_rs2_val;
    end else if (consume) begin
      held_valid_d = 1'b0;
      lock_d       = 1'b0;
    end else if (held_valid_q && !lock_q) begin
      if (ex_valid) begin
        // Back-pressured: freeze the operands currently on the bus.
        lock_d          = 1'b1;
        entry_d.rs1_val = rs1_fwd;
        entry_d.rs2_val = rs2_fwd;
      end else begin
        if (wb_hit1) entry_d.rs1_val = wb_result;
        if (wb_hit2) entry_d.rs2_val = wb_result;
      end
    end
  end

  // NOTE: the datapath is reset too so alu_a/alu_b/alu_control/ex_rd read zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      entry_q      <= '0;
      held_valid_q <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      held_valid_q <= held_valid_d;
      lock_q       <= lock_d;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage; expectations follow the build's EX_FWD_EN setting.
module tb_ex_issue_stage;

  localparam int WIDTH    = 32;
  localparam int REG_BITS = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid, id_ready;
  logic [WIDTH-1:0]    id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [REG_BITS-1:0] id_rs1, id_rs2, id_rd;
  logic                id_asel, id_bsel;
  logic [3:0]          id_alu_ctrl;
  logic                flush;
  logic                mem_wen, mem_is_load;
  logic [REG_BITS-1:0] mem_rd;
  logic [WIDTH-1:0]    mem_result;
  logic                wb_wen;
  logic [REG_BITS-1:0] wb_rd;
  logic [WIDTH-1:0]    wb_result;
  logic                ex_ready, ex_valid;
  logic [WIDTH-1:0]    alu_a, alu_b;
  logic [3:0]          alu_control;
  logic [REG_BITS-1:0] ex_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_issue_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_alu_ctrl(id_alu_ctrl),
    .flush(flush),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_rd(ex_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it before touching inputs or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = '0; id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_asel = 1'b0; id_bsel = 1'b0; id_alu_ctrl = 4'b0000;
    flush = 1'b0; mem_wen = 1'b0; mem_rd = '0; mem_is_load = 1'b0; mem_result = '0;
    wb_wen = 1'b0; wb_rd = '0; wb_result = '0; ex_ready = 1'b1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic asel, input logic bsel,
                       input logic [3:0] ctrl);
    id_valid = 1'b1; id_pc = pc; id_rs1_val = v1; id_rs2_val = v2; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_asel = asel; id_bsel = bsel; id_alu_ctrl = ctrl;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_id_ready", {31'b0, id_ready}, 32'd1);
    check("rst_alu_ctrl", {28'b0, alu_control}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
    rst_n = 1'b1;

    // Plain ADD, 10 + 10
    issue(32'h0, 32'd10, 32'd10, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 4'b0000);
    settle();
    check("add_id_ready", {31'b0, id_ready}, 32'd1);
    tick(); idle();
    settle();
    check("add_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("add_alu_a", alu_a, 32'd10);
    check("add_alu_b", alu_b, 32'd10);
    check("add_ctrl", {28'b0, alu_control}, 32'd0);
    check("add_ex_rd", {27'b0, ex_rd}, 32'd3);
    tick();
    check("add_consumed", {31'b0, ex_valid}, 32'd0);

    // PC/imm select with SUB
    issue(32'h100, 32'h1, 32'h2, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 4'b1000);
    tick(); idle();
    settle();
    check("sel_alu_a", alu_a, 32'h100);
    check("sel_alu_b", alu_b, 32'hFFFF_FFFC);
    check("sel_ctrl", {28'b0, alu_control}, 32'h8);
    tick();

    // mem vs wb on rs1=5
    issue(32'h0, 32'd1, 32'd0, 32'd4, 5'd5, 5'd0, 5'd7, 1'b0, 1'b1, 4'b0000);
    tick(); idle();
    mem_wen = 1'b1; mem_rd = 5'd5; mem_result = 32'd7;
    wb_wen = 1'b1; wb_rd = 5'd5; wb_result = 32'd3;
    settle();
`ifdef EX_FWD_EN
    check("fwd_valid", {31'b0, ex_valid}, 32'd1);
    check("fwd_mem_wins", alu_a, 32'd7);
    tick(); idle();
`else
    check("raw_stall1", {31'b0, ex_valid}, 32'd0);
    check("raw_stall1_rdy", {31'b0, id_ready}, 32'd0);
    tick();
    mem_wen = 1'b0;
    settle();
    check("raw_stall2", {31'b0, ex_valid}, 32'd0);
    tick(); idle();
    settle();
    check("raw_valid", {31'b0, ex_valid}, 32'd1);
    check("raw_refresh", alu_a, 32'd3);
    tick();
`endif

    // Load-use on rs2=6
    issue(32'h0, 32'd2, 32'h1111, 32'h0, 5'd1, 5'd6, 5'd8, 1'b0, 1'b0, 4'b0100);
    tick(); idle();
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd6; mem_result = 32'h5555;
    settle();
    check("lu_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_id_ready", {31'b0, id_ready}, 32'd0);
    tick(); idle();
    wb_wen = 1'b1; wb_rd = 5'd6; wb_result = 32'hDEAD;
    settle();
`ifndef EX_FWD_EN
    check("lu_wb_stall", {31'b0, ex_valid}, 32'd0);
    tick(); idle();
    settle();
`endif
    check("lu_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_alu_b", alu_b, 32'hDEAD);
    check("lu_alu_a", alu_a, 32'd2);
    check("lu_ctrl", {28'b0, alu_control}, 32'h4);
    tick(); idle();

    // Back-pressure 3 cycles, late wb to rs1 must not disturb the outputs
    issue(32'h0, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 4'b0110);
    ex_ready = 1'b0;
    tick(); idle();
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bp_valid_%0d", i), {31'b0, ex_valid}, 32'd1);
      check($sformatf("bp_rdy_%0d", i), {31'b0, id_ready}, 32'd0);
      check($sformatf("bp_a_%0d", i), alu_a, 32'h11);
      check($sformatf("bp_b_%0d", i), alu_b, 32'h22);
      check($sformatf("bp_ctrl_%0d", i), {28'b0, alu_control}, 32'h6);
      tick();
      wb_wen = 1'b1; wb_rd = 5'd1; wb_result = 32'h99;
    end
    idle();
    issue(32'h0, 32'h33, 32'h44, 32'h0, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 4'b0111);
    settle();
    check("swap_id_ready", {31'b0, id_ready}, 32'd1);
    check("swap_old_a", alu_a, 32'h11);
    tick(); idle();
    settle();
    check("swap_no_bubble", {31'b0, ex_valid}, 32'd1);
    check("swap_new_a", alu_a, 32'h33);
    check("swap_new_b", alu_b, 32'h44);
    check("swap_ex_rd", {27'b0, ex_rd}, 32'd10);
    tick();

    // Flush beats a same-cycle capture
    issue(32'h0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 4'b0000);
    flush = 1'b1;
    tick(); idle();
    settle();
    check("flush_drop", {31'b0, ex_valid}, 32'd0);
    check("flush_rdy", {31'b0, id_ready}, 32'd1);

    // Flush of a held, back-pressured op
    issue(32'h0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 4'b0011);
    ex_ready = 1'b0;
    tick(); idle();
    ex_ready = 1'b0;
    settle();
    check("flush_held_pre", {31'b0, ex_valid}, 32'd1);
    flush = 1'b1;
    tick(); idle();
    settle();
    check("flush_held_post", {31'b0, ex_valid}, 32'd0);

    // x0 is never forwarded or hazard-checked
    issue(32'h0, 32'h55, 32'h66, 32'h0, 5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 4'b0010);
    tick(); idle();
    mem_wen = 1'b1; mem_rd = 5'd0; mem_result = 32'h99; mem_is_load = 1'b1;
    wb_wen = 1'b1; wb_rd = 5'd0; wb_result = 32'h77;
    settle();
    check("x0_valid", {31'b0, ex_valid}, 32'd1);
    check("x0_alu_a", alu_a, 32'h55);
    check("x0_alu_b", alu_b, 32'h66);
    check("x0_ctrl", {28'b0, alu_control}, 32'h2);
    tick(); idle();
    settle();
    check("end_empty", {31'b0, ex_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
